// File: rtl/ex_mem_resolve.sv
// -----------------------------------------------------------------------------
// ex_mem_resolve
//
// Consumer side of the execute stage in the 16-bit pipeline. It registers EX
// results into the EX/MEM latch and owns the architectural N/Z/V flag
// register, which is fed back to EX as flagsOut. It resolves B/JAL/JR using
// the registered flags and the EX target address, and it issues a one-cycle
// PC redirect. Wrong-path slots are squashed by a flush counter. HLT is
// latched as a sticky halt.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   valid_in            EX holds a real instruction
//   stall               MEM back-pressure; every register holds
//   pc, instr           PC and encoding of the EX instruction
//   aluResult           EX ALU result
//   targetAddr          EX branch/jump target
//   flags, flagEn       EX flags {N,Z,V} and per-bit write mask (bit0 = V)
//   reg2In, dstIn       store data, destination register
//   regWrIn, memWrIn, memRdIn   control bits from decode
//   flagsOut            architectural flag register, back to EX
//   redirect            one-cycle redirect pulse to fetch
//   redirectPC          redirect target
//   flush               high while wrong-path slots are still being squashed
//   mem_*               EX/MEM latch contents
//   halted              sticky halt
// -----------------------------------------------------------------------------
module ex_mem_resolve #(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter logic [3:0]  OP_B         = 4'hC,
    parameter logic [3:0]  OP_JAL       = 4'hD,
    parameter logic [3:0]  OP_JR        = 4'hE,
    parameter logic [3:0]  OP_HLT       = 4'hF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic        stall,
    input  logic [15:0] pc,
    input  logic [15:0] instr,
    input  logic [15:0] aluResult,
    input  logic [15:0] targetAddr,
    input  logic [2:0]  flags,
    input  logic [2:0]  flagEn,
    input  logic [15:0] reg2In,
    input  logic [3:0]  dstIn,
    input  logic        regWrIn,
    input  logic        memWrIn,
    input  logic        memRdIn,
    output logic [2:0]  flagsOut,
    output logic        redirect,
    output logic [15:0] redirectPC,
    output logic        flush,
    output logic        mem_valid,
    output logic [15:0] mem_instr,
    output logic [15:0] mem_result,
    output logic [15:0] mem_storeData,
    output logic [3:0]  mem_dst,
    output logic        mem_regWr,
    output logic        mem_memWr,
    output logic        mem_memRd,
    output logic        halted
);

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

    // Branch condition evaluation against the flag register {N,Z,V}.
    function automatic logic cond_met(input logic [2:0] cond, input logic [2:0] f);
        logic n_s;
        logic z_s;
        logic v_s;
        logic res_s;
        n_s = f[2];
        z_s = f[1];
        v_s = f[0];
        case (cond)
            3'b000:  res_s = ~z_s;
            3'b001:  res_s = z_s;
            3'b010:  res_s = ~z_s & ~n_s;
            3'b011:  res_s = n_s;
            3'b100:  res_s = z_s | ~n_s;
            3'b101:  res_s = z_s | n_s;
            3'b110:  res_s = v_s;
            3'b111:  res_s = 1'b1;
            default: res_s = 1'b0;
        endcase
        return res_s;
    endfunction

    logic [3:0] opcode_s;
    logic       adv_s;
    logic       acc_s;
    logic       squash_s;
    logic       is_hlt_s;
    logic       is_jal_s;
    logic       xfer_s;
    logic       taken_s;
    logic [2:0] cnt_r;
    logic [2:0] cnt_next_s;
    logic [2:0] flags_next_s;

    // Decode, advance/accept qualification and control-transfer resolution.
    always_comb begin
        opcode_s = instr[15:12];
        adv_s    = ~stall;
        // Acceptance needs the squash window closed and no halt in effect.
        acc_s    = adv_s & valid_in & (cnt_r == 3'd0) & ~halted;
        // A squash consumes only real instructions. Bubbles leave the count alone.
        squash_s = adv_s & valid_in & (cnt_r != 3'd0);
        is_hlt_s = (opcode_s == OP_HLT);
        is_jal_s = (opcode_s == OP_JAL);
        if (opcode_s == OP_B) begin
            // Uses the pre-update flags, so a B never sees its own flag write.
            xfer_s = cond_met(instr[11:9], flagsOut);
        end else if ((opcode_s == OP_JAL) || (opcode_s == OP_JR)) begin
            xfer_s = 1'b1;
        end else begin
            xfer_s = 1'b0;
        end
        taken_s = acc_s & xfer_s;
    end

    // Next squash count: reload on a taken transfer, otherwise count squashed slots.
    always_comb begin
        if (taken_s) begin
            cnt_next_s = FLUSH_LOAD;
        end else if (squash_s) begin
            cnt_next_s = cnt_r - 3'd1;
        end else begin
            cnt_next_s = cnt_r;
        end
    end

    // Masked flag merge for an accepted instruction.
    always_comb begin
        if (acc_s) begin
            flags_next_s = (flagsOut & ~flagEn) | (flags & flagEn);
        end else begin
            flags_next_s = flagsOut;
        end
    end

    // Architectural state: flags, squash counter, redirect and halt.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flagsOut   <= 3'b000;
            cnt_r      <= 3'd0;
            flush      <= 1'b0;
            redirect   <= 1'b0;
            redirectPC <= 16'h0000;
            halted     <= 1'b0;
        end else begin
            flagsOut <= flags_next_s;
            cnt_r    <= cnt_next_s;
            flush    <= (cnt_next_s != 3'd0);
            // taken_s already implies !stall, so the pulse drops after one
            // cycle even when MEM stalls.
            redirect <= taken_s;
            if (taken_s) begin
                redirectPC <= targetAddr;
            end else begin
                redirectPC <= redirectPC;
            end
            if (acc_s && is_hlt_s) begin
                halted <= 1'b1;
            end else begin
                halted <= halted;
            end
        end
    end

    // EX/MEM latch. Data holds when no instruction is accepted, and control
    // bits are cleared so that a dropped slot has no side effects downstream.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_valid     <= 1'b0;
            mem_instr     <= 16'h0000;
            mem_result    <= 16'h0000;
            mem_storeData <= 16'h0000;
            mem_dst       <= 4'h0;
            mem_regWr     <= 1'b0;
            mem_memWr     <= 1'b0;
            mem_memRd     <= 1'b0;
        end else if (adv_s) begin
            mem_valid <= acc_s;
            if (acc_s) begin
                mem_instr     <= instr;
                mem_result    <= is_jal_s ? (pc + 16'd1) : aluResult;
                mem_storeData <= reg2In;
                mem_dst       <= dstIn;
                // HLT travels down the pipe as an inert marker.
                mem_regWr     <= regWrIn & ~is_hlt_s;
                mem_memWr     <= memWrIn & ~is_hlt_s;
                mem_memRd     <= memRdIn & ~is_hlt_s;
            end else begin
                mem_regWr <= 1'b0;
                mem_memWr <= 1'b0;
                mem_memRd <= 1'b0;
            end
        end else begin
            mem_valid <= mem_valid;
        end
    end

endmodule

// File: tb/tb_ex_mem_resolve.sv
// -----------------------------------------------------------------------------
// tb_ex_mem_resolve
//
// Directed-vector bench for ex_mem_resolve. A transaction-level reference
// model tracks flags, the remaining squash slots, halt state and the expected
// EX/MEM latch. A negedge compare process checks every output against that
// model. Hand-computed literal checks pin down the model itself.
// -----------------------------------------------------------------------------
module tb_ex_mem_resolve;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in, stall;
    logic [15:0] pc, instr, aluResult, targetAddr, reg2In;
    logic [2:0]  flags, flagEn;
    logic [3:0]  dstIn;
    logic        regWrIn, memWrIn, memRdIn;
    logic [2:0]  flagsOut;
    logic        redirect;
    logic [15:0] redirectPC;
    logic        flush;
    logic        mem_valid;
    logic [15:0] mem_instr, mem_result, mem_storeData;
    logic [3:0]  mem_dst;
    logic        mem_regWr, mem_memWr, mem_memRd;
    logic        halted;

    ex_mem_resolve dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .stall(stall),
        .pc(pc), .instr(instr), .aluResult(aluResult), .targetAddr(targetAddr),
        .flags(flags), .flagEn(flagEn), .reg2In(reg2In), .dstIn(dstIn),
        .regWrIn(regWrIn), .memWrIn(memWrIn), .memRdIn(memRdIn),
        .flagsOut(flagsOut), .redirect(redirect), .redirectPC(redirectPC),
        .flush(flush), .mem_valid(mem_valid), .mem_instr(mem_instr),
        .mem_result(mem_result), .mem_storeData(mem_storeData), .mem_dst(mem_dst),
        .mem_regWr(mem_regWr), .mem_memWr(mem_memWr), .mem_memRd(mem_memRd),
        .halted(halted)
    );

    always #5 clk = ~clk;

    int nVec = 0;
    int nErr = 0;
    bit cmpOn = 1'b0;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        nVec++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int          slotsLeft;      // wrong-path slots still to drop
    logic [2:0]  eFlags;
    logic        eRedirect, eHalt, eValid, eRw, eMw, eMr;
    logic [15:0] ePC, eInstr, eResult, eStore;
    logic [3:0]  eDst;

    // Whether an accepted instruction transfers control, given flags N,Z,V.
    function automatic bit transfers(input logic [15:0] ins, input logic [2:0] f);
        bit n, z, v;
        n = f[2]; z = f[1]; v = f[0];
        if (ins[15:12] == 4'hD || ins[15:12] == 4'hE) return 1'b1;
        if (ins[15:12] != 4'hC) return 1'b0;
        case (ins[11:9])
            3'd0: return !z;
            3'd1: return z;
            3'd2: return !z && !n;
            3'd3: return n;
            3'd4: return z || !n;
            3'd5: return z || n;
            3'd6: return v;
            default: return 1'b1;
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            slotsLeft <= 0; eFlags <= 3'b000; eRedirect <= 1'b0; eHalt <= 1'b0;
            eValid <= 1'b0; eRw <= 1'b0; eMw <= 1'b0; eMr <= 1'b0;
            ePC <= 16'h0; eInstr <= 16'h0; eResult <= 16'h0; eStore <= 16'h0; eDst <= 4'h0;
        end else begin
            eRedirect <= 1'b0;
            if (!stall) begin
                if (valid_in && slotsLeft > 0) begin
                    slotsLeft <= slotsLeft - 1;
                    eValid <= 1'b0; eRw <= 1'b0; eMw <= 1'b0; eMr <= 1'b0;
                end else if (valid_in && !eHalt) begin
                    eValid  <= 1'b1;
                    eInstr  <= instr;
                    eResult <= (instr[15:12] == 4'hD) ? pc + 16'd1 : aluResult;
                    eStore  <= reg2In;
                    eDst    <= dstIn;
                    if (instr[15:12] == 4'hF) begin
                        eHalt <= 1'b1; eRw <= 1'b0; eMw <= 1'b0; eMr <= 1'b0;
                    end else begin
                        eRw <= regWrIn; eMw <= memWrIn; eMr <= memRdIn;
                    end
                    for (int i = 0; i < 3; i++)
                        if (flagEn[i]) eFlags[i] <= flags[i];
                    if (transfers(instr, eFlags)) begin
                        eRedirect <= 1'b1;
                        ePC       <= targetAddr;
                        slotsLeft <= 2;
                    end
                end else begin
                    eValid <= 1'b0; eRw <= 1'b0; eMw <= 1'b0; eMr <= 1'b0;
                end
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (cmpOn) begin
            chk("flagsOut", {13'd0, flagsOut}, {13'd0, eFlags});
            chk("redirect", {15'd0, redirect}, {15'd0, eRedirect});
            chk("redirectPC", redirectPC, ePC);
            chk("flush", {15'd0, flush}, {15'd0, (slotsLeft != 0)});
            chk("mem_valid", {15'd0, mem_valid}, {15'd0, eValid});
            chk("mem_instr", mem_instr, eInstr);
            chk("mem_result", mem_result, eResult);
            chk("mem_storeData", mem_storeData, eStore);
            chk("mem_dst", {12'd0, mem_dst}, {12'd0, eDst});
            chk("mem_ctrl", {13'd0, mem_regWr, mem_memWr, mem_memRd}, {13'd0, eRw, eMw, eMr});
            chk("halted", {15'd0, halted}, {15'd0, eHalt});
        end
    end

    // Apply one vector just after a negedge, then wait for the next negedge.
    task automatic go(input logic v, input logic [15:0] ins, input logic [15:0] p,
                      input logic [15:0] alu, input logic [15:0] tgt,
                      input logic [2:0] fl, input logic [2:0] fe,
                      input logic rw, input logic mw, input logic st);
        #1;
        valid_in = v; instr = ins; pc = p; aluResult = alu; targetAddr = tgt;
        flags = fl; flagEn = fe; regWrIn = rw; memWrIn = mw; memRdIn = 1'b0;
        reg2In = alu ^ 16'hFFFF; dstIn = ins[3:0]; stall = st;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; valid_in = 1'b0; stall = 1'b0; pc = 16'h0; instr = 16'h0;
        aluResult = 16'h0; targetAddr = 16'h0; flags = 3'b0; flagEn = 3'b0;
        reg2In = 16'h0; dstIn = 4'h0; regWrIn = 1'b0; memWrIn = 1'b0; memRdIn = 1'b0;
        #3;
        chk("rst_flagsOut", {13'd0, flagsOut}, 16'd0);
        chk("rst_mem_valid", {15'd0, mem_valid}, 16'd0);
        chk("rst_redirect", {15'd0, redirect}, 16'd0);
        chk("rst_halted", {15'd0, halted}, 16'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0; cmpOn = 1'b1;

        // Flag write mask
        go(1'b1, 16'h1234, 16'h0001, 16'h1111, 16'h0, 3'b101, 3'b111, 1'b1, 1'b0, 1'b0);
        chk("t1_flags_a", {13'd0, flagsOut}, 16'h0005);
        chk("t1_result", mem_result, 16'h1111);
        go(1'b1, 16'h1235, 16'h0002, 16'h2222, 16'h0, 3'b010, 3'b010, 1'b1, 1'b0, 1'b0);
        chk("t1_flags_b", {13'd0, flagsOut}, 16'h0007);

        // Taken EQ, two squashed slots, third accepted
        go(1'b1, 16'hC200, 16'h0003, 16'h0, 16'h0040, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
        chk("t2_redirect", {15'd0, redirect}, 16'd1);
        chk("t2_redirectPC", redirectPC, 16'h0040);
        go(1'b1, 16'h1236, 16'h0004, 16'h3333, 16'h0, 3'b000, 3'b111, 1'b1, 1'b0, 1'b0);
        chk("t2_pulse_end", {15'd0, redirect}, 16'd0);
        chk("t2_sq1_valid", {15'd0, mem_valid}, 16'd0);
        chk("t2_sq1_flags", {13'd0, flagsOut}, 16'h0007);
        go(1'b1, 16'h1237, 16'h0005, 16'h3333, 16'h0, 3'b000, 3'b111, 1'b1, 1'b0, 1'b0);
        chk("t2_sq2_valid", {15'd0, mem_valid}, 16'd0);
        chk("t2_flush_done", {15'd0, flush}, 16'd0);
        go(1'b1, 16'h1238, 16'h0006, 16'h4444, 16'h0, 3'b010, 3'b111, 1'b1, 1'b0, 1'b0);
        chk("t2_acc_valid", {15'd0, mem_valid}, 16'd1);
        chk("t2_acc_flags", {13'd0, flagsOut}, 16'h0002);

        // Not-taken NE with Z=1, then a store accepted
        go(1'b1, 16'hC000, 16'h0007, 16'h0, 16'h0080, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
        chk("t3_redirect", {15'd0, redirect}, 16'd0);
        chk("t3_flush", {15'd0, flush}, 16'd0);
        go(1'b1, 16'h2001, 16'h0008, 16'h5555, 16'h0, 3'b000, 3'b000, 1'b0, 1'b1, 1'b0);
        chk("t3_next_valid", {15'd0, mem_valid}, 16'd1);
        // Not-taken OV (V=0) and GT (Z=1)
        go(1'b1, 16'hCC00, 16'h0009, 16'h0, 16'h0090, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
        chk("t3_ov_redirect", {15'd0, redirect}, 16'd0);
        go(1'b1, 16'hC400, 16'h000A, 16'h0, 16'h00A0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);

        // JAL
        go(1'b1, 16'hD00F, 16'h0010, 16'hDEAD, 16'h0100, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0);
        chk("t4_result", mem_result, 16'h0011);
        chk("t4_regWr", {15'd0, mem_regWr}, 16'd1);
        chk("t4_redirectPC", redirectPC, 16'h0100);

        // Stall during flush: everything holds, pulse still ends
        for (int i = 0; i < 3; i++) begin
            go(1'b1, 16'h1240, 16'h0011, 16'h6666, 16'h0, 3'b000, 3'b000, 1'b1, 1'b0, 1'b1);
            chk("t5_stall_flush", {15'd0, flush}, 16'd1);
            chk("t5_stall_hold", mem_result, 16'h0011);
        end
        chk("t5_pulse_end", {15'd0, redirect}, 16'd0);
        go(1'b1, 16'h1241, 16'h0012, 16'h6666, 16'h0, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0);
        chk("t5_sq_a", {15'd0, mem_valid}, 16'd0);
        chk("t5_cnt1", {15'd0, flush}, 16'd1);
        go(1'b0, 16'h1242, 16'h0013, 16'h6666, 16'h0, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0);
        chk("t5_bubble", {15'd0, flush}, 16'd1);
        go(1'b1, 16'h1243, 16'h0014, 16'h6666, 16'h0, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0);
        chk("t5_cnt0", {15'd0, flush}, 16'd0);
        go(1'b1, 16'h1244, 16'h0015, 16'h7777, 16'h0, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0);
        chk("t5_acc", {15'd0, mem_valid}, 16'd1);

        // Taken branch held off by stall, then squashed JR and HLT
        go(1'b1, 16'hCE00, 16'h0016, 16'h0, 16'h0200, 3'b000, 3'b000, 1'b0, 1'b0, 1'b1);
        chk("stall_br_redirect", {15'd0, redirect}, 16'd0);
        go(1'b1, 16'hCE00, 16'h0016, 16'h0, 16'h0200, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
        chk("br_redirectPC", redirectPC, 16'h0200);
        go(1'b1, 16'hE000, 16'h0017, 16'h0, 16'h0300, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
        chk("sq_jr_redirect", {15'd0, redirect}, 16'd0);
        go(1'b1, 16'hF000, 16'h0018, 16'h0, 16'h0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
        chk("sq_hlt", {15'd0, halted}, 16'd0);

        // HLT accepted, later input ignored
        go(1'b1, 16'hF000, 16'h0019, 16'h0, 16'h0, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0);
        chk("t6_halted", {15'd0, halted}, 16'd1);
        chk("t6_hlt_regWr", {15'd0, mem_regWr}, 16'd0);
        go(1'b1, 16'h1250, 16'h001A, 16'h8888, 16'h0, 3'b000, 3'b111, 1'b1, 1'b0, 1'b0);
        chk("t6_flags_frozen", {13'd0, flagsOut}, 16'h0002);
        chk("t6_ignored", {15'd0, mem_valid}, 16'd0);

        // Reset clears halt
        #2 rst = 1'b1;
        #1 chk("t6_rst_halted", {15'd0, halted}, 16'd0);
        @(negedge clk); rst = 1'b0;

        // Reset mid-flush
        go(1'b1, 16'hCE00, 16'h0020, 16'h0, 16'h0400, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
        chk("t6_br_flush", {15'd0, flush}, 16'd1);
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_flush", {15'd0, flush}, 16'd0);
        chk("t6_rst_redirect", {15'd0, redirect}, 16'd0);
        @(negedge clk); rst = 1'b0;
        go(1'b1, 16'h1260, 16'h0021, 16'h9999, 16'h0, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0);
        chk("t6_after_rst_acc", {15'd0, mem_valid}, 16'd1);

        cmpOn = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
